// File: rtl/pixycam_ccc_lock_seq.sv
// Lock-qualified staged reset sequencer for the pixyCam fabric.
// Releases resets in order once CCC lock is stable; drops all on loss.
module pixycam_ccc_lock_seq #(
  parameter int LOCK_FILTER = 16,
  parameter int STAGES      = 3,
  parameter int STAGE_GAP   = 8,
  parameter int CNT_W       = 8
) (
  input  logic              FAB_CLK,
  input  logic              M2F_RESET_N,
  input  logic              FAB_LOCK,
  input  logic              CLR_STATUS,
  output logic [STAGES-1:0] RST_OUT_N,
  output logic              READY,
  output logic              LOCK_LOST,
  output logic [CNT_W-1:0]  LOSS_COUNT
);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    FILTER,
    RELEASE,
    RUN
  } state_t;

  localparam logic [7:0]       FLT_LAST = 8'(LOCK_FILTER - 1);
  localparam logic [7:0]       GAP_LAST = 8'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t      st;
  logic        s1;
  logic        lk;
  logic [7:0]  flt_cnt;
  logic [7:0]  gap_cnt;

  // Stages release as a thermometer: next pattern shifts in one more '1'.
  logic [STAGES-1:0] nxt_rel;
  assign nxt_rel = STAGES'({RST_OUT_N, 1'b1});

  always_ff @(posedge FAB_CLK) begin
    if (!M2F_RESET_N) begin
      s1         <= 1'b0;
      lk         <= 1'b0;
      st         <= WAIT_LOCK;
      flt_cnt    <= '0;
      gap_cnt    <= '0;
      RST_OUT_N  <= '0;
      READY      <= 1'b0;
      LOCK_LOST  <= 1'b0;
      LOSS_COUNT <= '0;
    end else begin
      s1 <= FAB_LOCK;
      lk <= s1;
      if (CLR_STATUS) begin
        LOCK_LOST  <= 1'b0;
        LOSS_COUNT <= '0;
      end
      unique case (st)
        WAIT_LOCK: begin
          if (lk) begin
            st      <= FILTER;
            flt_cnt <= 8'd1;
          end
        end
        FILTER: begin
          if (!lk) begin
            st      <= WAIT_LOCK;
            flt_cnt <= '0;
          end else if (flt_cnt == FLT_LAST) begin
            flt_cnt   <= '0;
            gap_cnt   <= '0;
            RST_OUT_N <= nxt_rel;
            READY     <= &nxt_rel;
            st        <= (&nxt_rel) ? RUN : RELEASE;
          end else begin
            flt_cnt <= flt_cnt + 8'd1;
          end
        end
        RELEASE, RUN: begin
          if (!lk) begin
            // Clear (if any) is overridden by the loss on the same edge.
            st         <= WAIT_LOCK;
            gap_cnt    <= '0;
            RST_OUT_N  <= '0;
            READY      <= 1'b0;
            LOCK_LOST  <= 1'b1;
            if (CLR_STATUS)
              LOSS_COUNT <= CNT_W'(1);
            else if (LOSS_COUNT != CNT_MAX)
              LOSS_COUNT <= LOSS_COUNT + CNT_W'(1);
          end else if (st == RELEASE) begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt   <= '0;
              RST_OUT_N <= nxt_rel;
              if (&nxt_rel) begin
                READY <= 1'b1;
                st    <= RUN;
              end
            end else begin
              gap_cnt <= gap_cnt + 8'd1;
            end
          end
        end
        default: st <= WAIT_LOCK;
      endcase
    end
  end

endmodule

// File: tb/tb_pixycam_ccc_lock_seq.sv
// Directed bench for pixycam_ccc_lock_seq: default build, a
// single-stage short-filter build, and a 2-bit loss counter build.
module tb_pixycam_ccc_lock_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lock;
  logic       clr;

  logic [2:0] r0;
  logic       rdy0, lost0;
  logic [7:0] cnt0;

  logic [0:0] r1;
  logic       rdy1, lost1;
  logic [7:0] cnt1;

  logic [2:0] r2;
  logic       rdy2, lost2;
  logic [1:0] cnt2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pixycam_ccc_lock_seq dut0 (
    .FAB_CLK(clk), .M2F_RESET_N(rst_n), .FAB_LOCK(lock),
    .CLR_STATUS(clr), .RST_OUT_N(r0), .READY(rdy0),
    .LOCK_LOST(lost0), .LOSS_COUNT(cnt0)
  );

  pixycam_ccc_lock_seq #(.LOCK_FILTER(2), .STAGES(1)) dut1 (
    .FAB_CLK(clk), .M2F_RESET_N(rst_n), .FAB_LOCK(lock),
    .CLR_STATUS(clr), .RST_OUT_N(r1), .READY(rdy1),
    .LOCK_LOST(lost1), .LOSS_COUNT(cnt1)
  );

  pixycam_ccc_lock_seq #(.CNT_W(2)) dut2 (
    .FAB_CLK(clk), .M2F_RESET_N(rst_n), .FAB_LOCK(lock),
    .CLR_STATUS(clr), .RST_OUT_N(r2), .READY(rdy2),
    .LOCK_LOST(lost2), .LOSS_COUNT(cnt2)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk0(input string tag, input logic [2:0] r,
                      input logic rdy, input logic lost,
                      input logic [7:0] c);
    chk({tag, ".rst"}, 32'(r0), 32'(r));
    chk({tag, ".ready"}, 32'(rdy0), 32'(rdy));
    chk({tag, ".lost"}, 32'(lost0), 32'(lost));
    chk({tag, ".cnt"}, 32'(cnt0), 32'(c));
  endtask

  initial begin
    rst_n = 1'b0;
    lock  = 1'b0;
    clr   = 1'b0;
    tick(3);
    chk0("reset", 3'b000, 1'b0, 1'b0, 8'd0);
    chk("reset.d1_rst", 32'(r1), 32'd0);
    chk("reset.d2_cnt", 32'(cnt2), 32'd0);
    rst_n = 1'b1;

    // first lock: first sampled at edge k = next edge
    lock = 1'b1;
    tick(3);
    chk("d1_k2.rst", 32'(r1), 32'd0);
    chk("d1_k2.ready", 32'(rdy1), 32'd0);
    tick(1);
    chk("d1_k3.rst", 32'(r1), 32'd1);
    chk("d1_k3.ready", 32'(rdy1), 32'd1);
    tick(13);
    chk0("lock_k16", 3'b000, 1'b0, 1'b0, 8'd0);
    tick(1);
    chk0("lock_k17", 3'b001, 1'b0, 1'b0, 8'd0);
    tick(7);
    chk0("lock_k24", 3'b001, 1'b0, 1'b0, 8'd0);
    tick(1);
    chk0("lock_k25", 3'b011, 1'b0, 1'b0, 8'd0);
    tick(7);
    chk0("lock_k32", 3'b011, 1'b0, 1'b0, 8'd0);
    tick(1);
    chk0("lock_k33", 3'b111, 1'b1, 1'b0, 8'd0);
    chk("d2_k33.rst", 32'(r2), 32'd7);

    // loss in RUN: first sampled low at m = next edge
    lock = 1'b0;
    tick(2);
    chk0("run_loss_m1", 3'b111, 1'b1, 1'b0, 8'd0);
    tick(1);
    chk0("run_loss_m2", 3'b000, 1'b0, 1'b1, 8'd1);
    chk("run_loss.d1_cnt", 32'(cnt1), 32'd1);
    chk("run_loss.d1_ready", 32'(rdy1), 32'd0);

    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk0("clr", 3'b000, 1'b0, 1'b0, 8'd0);

    // re-lock, then loss while only stage 0 is released
    lock = 1'b1;
    tick(18);
    chk0("relock_k17", 3'b001, 1'b0, 1'b0, 8'd0);
    lock = 1'b0;
    tick(3);
    chk0("mid_loss", 3'b000, 1'b0, 1'b1, 8'd1);

    // second mid-release loss with a coincident clear
    lock = 1'b1;
    tick(18);
    chk0("relock2_k17", 3'b001, 1'b0, 1'b1, 8'd1);
    lock = 1'b0;
    tick(2);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk0("clr_and_loss", 3'b000, 1'b0, 1'b1, 8'd1);
    chk("clr_and_loss.d2_cnt", 32'(cnt2), 32'd1);

    // filter glitch: lock drops for two cycles during filtering
    lock = 1'b1;
    tick(11);
    lock = 1'b0;
    tick(2);
    lock = 1'b1;
    tick(5);
    chk0("glitch_old_k17", 3'b000, 1'b0, 1'b1, 8'd1);
    tick(12);
    chk0("glitch_k16", 3'b000, 1'b0, 1'b1, 8'd1);
    tick(1);
    chk0("glitch_k17", 3'b001, 1'b0, 1'b1, 8'd1);
    lock = 1'b0;
    tick(3);
    chk0("glitch_loss", 3'b000, 1'b0, 1'b1, 8'd2);
    chk("glitch_loss.d2_cnt", 32'(cnt2), 32'd2);

    // saturation of the 2-bit counter
    for (int i = 0; i < 4; i++) begin
      lock = 1'b1;
      tick(18);
      lock = 1'b0;
      tick(3);
      chk("sat.d0_cnt", 32'(cnt0), 32'(3 + i));
      chk("sat.d2_cnt", 32'(cnt2), 32'd3);
    end
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("sat_clr.d2_cnt", 32'(cnt2), 32'd0);
    chk("sat_clr.d2_lost", 32'(lost2), 32'd0);
    chk("sat_clr.d0_cnt", 32'(cnt0), 32'd0);

    // reset mid-sequence with LOSS_COUNT=2 and stages 011
    for (int i = 0; i < 2; i++) begin
      lock = 1'b1;
      tick(18);
      lock = 1'b0;
      tick(3);
    end
    lock = 1'b1;
    tick(26);
    chk0("pre_reset", 3'b011, 1'b0, 1'b1, 8'd2);
    rst_n = 1'b0;
    tick(1);
    chk0("mid_reset", 3'b000, 1'b0, 1'b0, 8'd0);
    chk("mid_reset.d1_rst", 32'(r1), 32'd0);
    chk("mid_reset.d2_cnt", 32'(cnt2), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(17);
    chk0("post_reset_k16", 3'b000, 1'b0, 1'b0, 8'd0);
    tick(1);
    chk0("post_reset_k17", 3'b001, 1'b0, 1'b0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
